// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the RISC-V pipeline.
// It takes the EX/MEM bundle, aligns store data onto byte lanes and drives
// a valid/ready data-memory port. It extracts and extends load data and
// emits a single-cycle writeback bundle.
// Optional feature: define MEM_TIMEOUT_EN to abort a load with bus_err if no
// response arrives within WAIT_TIMEOUT cycles.
module mem_access_unit #(
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_wdata,
  output logic        ex_ready,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OP_IMM = 5'b00100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  rd_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic        is_load_r;

  logic [4:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        writes_rd_s;
  logic        illegal_s;
  logic        misalign_s;
  logic [3:0]  st_we_s;
  logic [31:0] st_wdata_s;
  logic        unused_s;

  // Extract the addressed byte/halfword/word from a read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = rdata[8*lo +: 8];
    half_v = rdata[16*lo[1] +: 16];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  res_v = {24'd0, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b101:  res_v = {16'd0, half_v};
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  assign ex_ready = (state_r == IDLE);

  // Fields the decode ignores; folded here so they are visibly consumed.
  assign unused_s = ^{ex_inst[31:15], ex_inst[1:0], 8'(WAIT_TIMEOUT)};

  // Decode the incoming bundle: class, legality, alignment and store lanes.
  always_comb begin
    opcode_s    = ex_inst[6:2];
    funct3_s    = ex_inst[14:12];
    rd_s        = ex_inst[11:7];
    is_load_s   = (opcode_s == OP_LOAD);
    is_store_s  = (opcode_s == OP_STORE);
    writes_rd_s = 1'b0;
    illegal_s   = 1'b0;
    misalign_s  = 1'b0;
    st_we_s     = 4'b1111;
    st_wdata_s  = ex_wdata;

    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OP_IMM, OP_LOAD: writes_rd_s = 1'b1;
      default: writes_rd_s = 1'b0;
    endcase

    if (is_load_s) begin
      case (funct3_s)
        3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
        default:                illegal_s = 1'b0;
      endcase
    end else if (is_store_s) begin
      illegal_s = funct3_s[2] | (funct3_s[1:0] == 2'b11);
    end else begin
      illegal_s = 1'b0;
    end

    case (funct3_s[1:0])
      2'b01:   misalign_s = ex_alu[0];
      2'b10:   misalign_s = (ex_alu[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase

    case (funct3_s[1:0])
      2'b00: begin
        st_we_s    = 4'b0001 << ex_alu[1:0];
        st_wdata_s = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_we_s    = ex_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata_s = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_we_s    = 4'b1111;
        st_wdata_s = ex_wdata;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
`else
  assign bus_err = 1'b0;
`endif

  // Main FSM: accepts bundles, runs the memory handshake, registers all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      wb_valid       <= 1'b0;
      wb_we          <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= 32'd0;
      misaligned     <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_we        <= 4'b0000;
      dmem_wdata     <= 32'd0;
      rd_r           <= 5'd0;
      funct3_r       <= 3'd0;
      addr_lo_r      <= 2'd0;
      is_load_r      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err        <= 1'b0;
      wait_cnt_r     <= 8'd0;
`endif
    end else begin
      // Pulse outputs default low; individual branches raise them.
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (ex_valid) begin
            if (!(is_load_s || is_store_s)) begin
              wb_valid <= 1'b1;
              wb_we    <= writes_rd_s && (rd_s != 5'd0);
              wb_rd    <= rd_s;
              wb_data  <= ex_alu;
            end else if (illegal_s) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd_s;
              wb_data  <= ex_alu;
            end else if (misalign_s) begin
              misaligned <= 1'b1;
            end else begin
              state_r        <= REQ;
              dmem_req_valid <= 1'b1;
              dmem_addr      <= {ex_alu[31:2], 2'b00};
              dmem_we        <= is_store_s ? st_we_s : 4'b0000;
              dmem_wdata     <= is_store_s ? st_wdata_s : 32'd0;
              rd_r           <= rd_s;
              funct3_r       <= funct3_s;
              addr_lo_r      <= ex_alu[1:0];
              is_load_r      <= is_load_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            dmem_we        <= 4'b0000;
            if (is_load_r) begin
              state_r <= WAIT_RESP;
`ifdef MEM_TIMEOUT_EN
              wait_cnt_r <= 8'd0;
`endif
            end else begin
              state_r  <= IDLE;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd_r;
            end
          end else begin
            state_r <= REQ;
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_valid) begin
            state_r  <= IDLE;
            wb_valid <= 1'b1;
            wb_we    <= (rd_r != 5'd0);
            wb_rd    <= rd_r;
            wb_data  <= load_extract(funct3_r, addr_lo_r, dmem_rdata);
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt_r == 8'(WAIT_TIMEOUT - 32'd1)) begin
            state_r <= IDLE;
            bus_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
`else
          else begin
            state_r <= WAIT_RESP;
          end
`endif
        end
        default: begin
          state_r        <= IDLE;
          dmem_req_valid <= 1'b0;
          dmem_we        <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// instruction traffic compared against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_alu;
  logic [31:0] ex_wdata;
  logic        ex_ready;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_err;

  int check_cnt = 0;
  int error_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_alu(ex_alu), .ex_wdata(ex_wdata),
    .ex_ready(ex_ready),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, rd, op, 2'b11};
  endfunction

  function automatic bit model_writes(input logic [4:0] op);
    return op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b01100, 5'b00100, 5'b00000};
  endfunction

  function automatic int model_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit model_legal(input bit is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else         return f3 inside {3'd0, 3'd1, 3'd2};
  endfunction

  // Little-endian assembly of n bytes starting at the lane offset, then extension.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int lo,
                                             input logic [2:0] f3);
    int n;
    logic [31:0] val;
    n = model_size(f3);
    val = 32'd0;
    for (int k = 0; k < n; k++)
      val = val | (((rdata >> (8 * (lo + k))) & 32'hFF) << (8 * k));
    if (!f3[2] && n < 4 && (((val >> (8 * n - 1)) & 32'd1) == 32'd1))
      val = val - (32'd1 << (8 * n));
    return val;
  endfunction

  function automatic logic [31:0] model_st_we(input int lo, input logic [2:0] f3);
    logic [31:0] we;
    we = 32'd0;
    for (int k = 0; k < model_size(f3); k++) we = we | (32'd1 << (lo + k));
    return we;
  endfunction

  function automatic logic [31:0] model_st_data(input logic [31:0] wd, input logic [2:0] f3);
    if (model_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (model_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // Issue one bundle and follow it through to writeback, checking every step.
  task automatic do_txn(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] wd,
                        input int req_dly, input int resp_dly, input logic [31:0] rdata);
    logic [4:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    bit is_mem, is_load, mis;
    int n;
    op = inst[6:2];
    f3 = inst[14:12];
    rd = inst[11:7];
    is_load = (op == 5'b00000);
    is_mem  = is_load || (op == 5'b01000);
    n = model_size(f3);
    mis = (n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00);
    check("accept_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_inst = inst; ex_alu = alu; ex_wdata = wd;
    tick();
    ex_valid = 1'b0;
    if (!is_mem) begin
      check("alu_wb_valid", wb_valid, 1);
      check("alu_wb_rd", wb_rd, rd);
      check("alu_wb_data", wb_data, alu);
      check("alu_wb_we", wb_we, model_writes(op) && rd != 0);
      check("alu_ex_ready", ex_ready, 1);
      check("alu_no_req", dmem_req_valid, 0);
    end else if (!model_legal(is_load, f3)) begin
      check("ill_wb_valid", wb_valid, 1);
      check("ill_wb_we", wb_we, 0);
      check("ill_no_req", dmem_req_valid, 0);
      check("ill_ex_ready", ex_ready, 1);
    end else if (mis) begin
      check("mis_pulse", misaligned, 1);
      check("mis_wb_valid", wb_valid, 0);
      check("mis_no_req", dmem_req_valid, 0);
      check("mis_ex_ready", ex_ready, 1);
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        check("req_valid", dmem_req_valid, 1);
        check("req_addr", dmem_addr, alu & 32'hFFFF_FFFC);
        check("req_we", dmem_we, is_load ? 32'd0 : model_st_we(alu[1:0], f3));
        if (!is_load) check("req_wdata", dmem_wdata, model_st_data(wd, f3));
        check("req_busy", ex_ready, 0);
        check("req_no_wb", wb_valid, 0);
        if (i < req_dly) begin
          // Upstream offers a bundle and a stray response while busy; both must be ignored.
          ex_valid = 1'b1; ex_inst = 32'h00100093;
          dmem_resp_valid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
          tick();
        end
      end
      ex_valid = 1'b0; dmem_resp_valid = 1'b0; dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      check("hs_req_drop", dmem_req_valid, 0);
      if (!is_load) begin
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_we", wb_we, 0);
        check("st_ex_ready", ex_ready, 1);
      end else begin
        for (int i = 0; i <= resp_dly; i++) begin
          check("ld_wait_busy", ex_ready, 0);
          check("ld_wait_no_wb", wb_valid, 0);
          if (i < resp_dly) tick();
        end
        dmem_resp_valid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_resp_valid = 1'b0;
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_rd", wb_rd, rd);
        check("ld_wb_data", wb_data, model_load(rdata, alu[1:0], f3));
        check("ld_wb_we", wb_we, rd != 0);
        check("ld_ex_ready", ex_ready, 1);
      end
    end
    tick();
    check("pulse_wb_clear", wb_valid, 0);
    check("pulse_mis_clear", misaligned, 0);
  endtask

  logic [4:0] op_tbl [11];

  initial begin
    logic [31:0] a;
    logic [4:0]  op;
    op_tbl = '{5'b00000, 5'b01000, 5'b01100, 5'b00100, 5'b01101, 5'b00101,
               5'b11011, 5'b11001, 5'b11000, 5'b11100, 5'b00011};
    rst = 1'b1; ex_valid = 1'b0; ex_inst = 32'd0; ex_alu = 32'd0; ex_wdata = 32'd0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick(); tick();
    check("rst_ex_ready", ex_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_dmem_we", dmem_we, 0);
    rst = 1'b0;
    tick();

    // ADDI x5 then back-to-back ALU ops.
    do_txn(mk_inst(5'b00100, 3'd0, 5'd5), 32'h1234, 32'd0, 0, 0, 32'd0);
    ex_valid = 1'b1; ex_inst = mk_inst(5'b01100, 3'd0, 5'd7); ex_alu = 32'h55;
    tick();
    ex_inst = mk_inst(5'b01101, 3'd0, 5'd0); ex_alu = 32'h66;
    check("b2b_first_data", wb_data, 32'h55);
    check("b2b_ready", ex_ready, 1);
    tick();
    ex_valid = 1'b0;
    check("b2b_second_data", wb_data, 32'h66);
    check("b2b_x0_we", wb_we, 0);
    tick();
    // SB lane 2, LH/LHU sign behaviour, misaligned LW, LW into x0.
    do_txn(mk_inst(5'b01000, 3'd0, 5'd0), 32'h1002, 32'hAABBCCDD, 2, 0, 32'd0);
    do_txn(mk_inst(5'b00000, 3'd1, 5'd9), 32'h2002, 32'd0, 0, 0, 32'h80FF_1234);
    do_txn(mk_inst(5'b00000, 3'd5, 5'd9), 32'h2002, 32'd0, 0, 0, 32'h80FF_1234);
    do_txn(mk_inst(5'b00000, 3'd2, 5'd3), 32'h3001, 32'd0, 0, 0, 32'd0);
    do_txn(mk_inst(5'b00000, 3'd2, 5'd0), 32'h4000, 32'd0, 1, 1, 32'hDEADBEEF);
    do_txn(mk_inst(5'b01000, 3'd5, 5'd0), 32'h4000, 32'h1, 0, 0, 32'd0);

    // Reset while waiting for a load response; the late response must vanish.
    ex_valid = 1'b1; ex_inst = mk_inst(5'b00000, 3'd2, 5'd4); ex_alu = 32'h5000;
    tick();
    ex_valid = 1'b0; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check("rstmid_in_wait", ex_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_ready", ex_ready, 1);
    check("rstmid_no_req", dmem_req_valid, 0);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_resp_valid = 1'b0;
    check("rstmid_late_resp", wb_valid, 0);
    check("rstmid_still_idle", ex_ready, 1);

`ifdef MEM_TIMEOUT_EN
    // No response: bus_err after four cycles in WAIT_RESP.
    ex_valid = 1'b1; ex_inst = mk_inst(5'b00000, 3'd2, 5'd6); ex_alu = 32'h6000;
    tick();
    ex_valid = 1'b0; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    tick(); tick(); tick();
    check("to_not_yet", bus_err, 0);
    check("to_still_busy", ex_ready, 0);
    tick();
    check("to_bus_err", bus_err, 1);
    check("to_wb_valid", wb_valid, 0);
    check("to_ready", ex_ready, 1);
    tick();
    check("to_pulse_clear", bus_err, 0);
`endif

    // Randomized traffic across all opcode classes, widths and lane offsets.
    for (int t = 0; t < 400; t++) begin
      op = op_tbl[$urandom_range(0, 10)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_txn(mk_inst(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
